ad9228_capture_ctrl: RTL and testbench

AD9228_CAPTURE_CTRL -- requirements
Module: ad9228_capture_ctrl

---
 rtl/ad9228_pkg.sv | 20 ++
 rtl/ad9228_capture_ctrl_if.sv | 19 +
 rtl/ad9228_capture_ctrl_rr_arbiter.sv | 47 ++++
 rtl/ad9228_capture_ctrl.sv | 167 ++++++++++++++++
 tb/tb_ad9228_capture_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ad9228_pkg.sv
// Shared types and default sizing for the AD9228 capture controller slice.
package ad9228_pkg;

    localparam int NUM_CH_DEF         = 4;
    localparam int DATA_WIDTH_DEF     = 12;
    localparam int NUM_READS_BITS_DEF = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } cap_state_t;

    // Width of a channel index; never zero so a single-channel build still has a port.
    function automatic int ch_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ad9228_capture_ctrl_if.sv
// Output sample stream of the capture controller (valid/ready with channel tag and last flag).
interface ad9228_capture_ctrl_if #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 12
);
    import ad9228_pkg::*;

    localparam int CH_W = ch_bits(NUM_CH);

    logic [DATA_WIDTH-1:0] m_data;
    logic [CH_W-1:0]       m_ch;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;

    modport master (output m_data, m_ch, m_valid, m_last, input m_ready);
    modport slave  (input m_data, m_ch, m_valid, m_last, output m_ready);

endinterface

// File: rtl/ad9228_capture_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among requesters, highest priority starts at ptr.
module rr_arbiter
    import ad9228_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int PW = ch_bits(N);

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;

    // Pick the first requester at or after ptr, wrapping around.
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    always_comb begin
        grant = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                grant = '0;
                grant[(int'(ptr) + k) % N] = 1'b1;
            end
        end
    end

    // Next pointer: the channel just after the granted one.
    always_comb begin
        ptr_nxt = ptr;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) ptr_nxt = PW'((i + 1) % N);
        end
    end

    // Pointer register: back to channel 0 on reset or a new capture.
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)     ptr <= '0;
        else if (clr)  ptr <= '0;
        else           ptr <= ptr_nxt;
    end

endmodule

// File: rtl/ad9228_capture_ctrl.sv
// Capture controller: gathers per-channel deserializer words for a requested number of
// frames, buffers one word per channel and serialises them round-robin onto a stream.
module ad9228_capture_ctrl
    import ad9228_pkg::*;
#(
    parameter int NUM_CH         = NUM_CH_DEF,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int NUM_READS_BITS = NUM_READS_BITS_DEF
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                start,
    input  logic                                abort,
    input  logic [NUM_READS_BITS-1:0]           num_reads,
    input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]   ch_data,
    input  logic [NUM_CH-1:0]                   ch_valid,
    ad9228_capture_ctrl_if.master               m,
    output logic                                busy,
    output logic                                done,
    output logic                                overflow
);

    localparam int CH_W = ch_bits(NUM_CH);

    cap_state_t                state;
    logic [1:0]                rst_sync;
    logic [NUM_READS_BITS-1:0] reads_q;
    logic [NUM_READS_BITS-1:0] frame_cnt;
    logic [NUM_READS_BITS-1:0] frame_nxt;
    logic [NUM_CH-1:0]         buf_full;
    logic [DATA_WIDTH-1:0]     buf_data [NUM_CH];
    logic [NUM_CH-1:0]         accept;
    logic [NUM_CH-1:0]         arb_req;
    logic [NUM_CH-1:0]         grant;
    logic [CH_W-1:0]           grant_idx;
    logic                      start_acc;
    logic                      last_frame;
    logic                      drop;
    logic                      out_load;
    logic                      out_valid;
    logic                      out_last;
    logic [DATA_WIDTH-1:0]     out_data;
    logic [CH_W-1:0]           out_ch;

    assign start_acc  = (state == IDLE) && start && !abort && rst_sync[1];
    assign frame_nxt  = frame_cnt + NUM_READS_BITS'(1);
    assign last_frame = (frame_nxt == reads_q);
    assign out_load   = !out_valid || m.m_ready;
    assign arb_req    = (out_load && !abort) ? buf_full : '0;
    assign drop       = |(accept & buf_full & ~grant);

    // Which channel pulses are taken this cycle: ARM waits for channel 0, CAPTURE takes all.
    always_comb begin
        accept = '0;
        if (!abort) begin
            if (state == ARM && ch_valid[0]) accept = ch_valid;
            else if (state == CAPTURE)       accept = ch_valid;
        end
    end

    // Encode the one-hot grant into a channel number.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) grant_idx = CH_W'(i);
        end
    end

    rr_arbiter #(.N(NUM_CH)) u_arb (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (start_acc),
        .req   (arb_req),
        .grant (grant)
    );

    // Reset release is re-timed to clk; IDLE will not accept start until it has propagated.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rst_sync <= '0;
        else       rst_sync <= {rst_sync[0], 1'b1};
    end

    // Capture FSM with registered busy/done/overflow status.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            reads_q   <= '0;
            frame_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (drop) overflow <= 1'b1;
            if (abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start_acc) begin
                        reads_q   <= num_reads;
                        frame_cnt <= '0;
                        overflow  <= 1'b0;
                        if (num_reads == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= ARM;
                            busy  <= 1'b1;
                        end
                    end
                    ARM, CAPTURE: if (ch_valid[0]) begin
                        frame_cnt <= frame_nxt;
                        state     <= last_frame ? DRAIN : CAPTURE;
                    end
                    DRAIN: if (buf_full == '0 && !out_valid) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Holding-buffer occupancy: granted entries free, accepted words fill (a drop keeps the old word).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)      buf_full <= '0;
        else if (abort) buf_full <= '0;
        else            buf_full <= (buf_full & ~grant) | accept;
    end

    // Holding-buffer payload, written only when the word is actually kept.
    // NOTE: data storage has no reset; the full flags alone decide whether a word is meaningful.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (accept[i] && (!buf_full[i] || grant[i])) buf_data[i] <= ch_data[i];
        end
    end

    // Output register: reloads when empty or when the current beat is taken.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (abort) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (out_load) begin
            out_valid <= |grant;
            out_last  <= 1'b0;
            if (|grant) begin
                out_data <= buf_data[grant_idx];
                out_ch   <= grant_idx;
                out_last <= (state == DRAIN) && ((buf_full & ~grant) == '0);
            end
        end
    end

    assign m.m_valid = out_valid;
    assign m.m_last  = out_last;
    assign m.m_data  = out_data;
    assign m.m_ch    = out_ch;

endmodule

// File: tb/tb_ad9228_capture_ctrl.sv
// Self-checking bench for ad9228_capture_ctrl: expected beats are queued as stimulus is
// driven and popped by a monitor as the stream delivers them.
module tb_ad9228_capture_ctrl;
    import ad9228_pkg::*;

    localparam int NC  = 4;
    localparam int DW  = 12;
    localparam int NRB = 16;

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    ch;
        logic          last;
    } beat_t;

    logic                  clk = 1'b0;
    logic                  rstn = 1'b0;
    logic                  start = 1'b0;
    logic                  abort = 1'b0;
    logic [NRB-1:0]        num_reads = '0;
    logic [NC-1:0][DW-1:0] ch_data = '0;
    logic [NC-1:0]         ch_valid = '0;
    logic                  busy, done, overflow;

    ad9228_capture_ctrl_if #(.NUM_CH(NC), .DATA_WIDTH(DW)) m_if ();

    ad9228_capture_ctrl #(.NUM_CH(NC), .DATA_WIDTH(DW), .NUM_READS_BITS(NRB)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .abort     (abort),
        .num_reads (num_reads),
        .ch_data   (ch_data),
        .ch_valid  (ch_valid),
        .m         (m_if),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    beat_t          exp_q[$];
    beat_t          mon_exp;
    int             vec_cnt  = 0;
    int             err_cnt  = 0;
    int             beat_cnt = 0;
    int             done_cnt = 0;
    logic           prev_stall = 1'b0;
    logic [DW-1:0]  prev_data = '0;
    logic [1:0]     prev_ch = '0;
    logic           prev_last = 1'b0;
    logic [DW-1:0]  d0;

    // Stream monitor: scoreboard pop on each handshake, hold check while stalled, done counter.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (prev_stall && m_if.m_valid === 1'b1) begin
            vec_cnt++;
            if ({m_if.m_data, m_if.m_ch, m_if.m_last} !== {prev_data, prev_ch, prev_last}) begin
                err_cnt++;
                $display("FAIL stall_hold: got data=%h ch=%0d last=%b required data=%h ch=%0d last=%b",
                         m_if.m_data, m_if.m_ch, m_if.m_last, prev_data, prev_ch, prev_last);
            end
        end
        if (m_if.m_valid === 1'b1 && m_if.m_ready === 1'b1) begin
            beat_cnt++;
            vec_cnt++;
            if (exp_q.size() == 0) begin
                err_cnt++;
                $display("FAIL beat: got unexpected beat data=%h ch=%0d, required no beat",
                         m_if.m_data, m_if.m_ch);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({m_if.m_data, m_if.m_ch, m_if.m_last} !== {mon_exp.data, mon_exp.ch, mon_exp.last}) begin
                    err_cnt++;
                    $display("FAIL beat: got data=%h ch=%0d last=%b required data=%h ch=%0d last=%b",
                             m_if.m_data, m_if.m_ch, m_if.m_last, mon_exp.data, mon_exp.ch, mon_exp.last);
                end
            end
        end
        prev_stall = (m_if.m_valid === 1'b1) && (m_if.m_ready === 1'b0);
        prev_data  = m_if.m_data;
        prev_ch    = m_if.m_ch;
        prev_last  = m_if.m_last;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [NRB-1:0] nr);
        num_reads = nr;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    // One-cycle pulse on the masked channels with fresh random words; optionally queue them.
    task automatic pulse(input logic [NC-1:0] mask, input bit acc, input bit fin);
        int    top_ch;
        beat_t b;
        top_ch = 0;
        for (int i = 0; i < NC; i++) begin
            ch_data[i] = DW'($urandom);
            if (mask[i]) top_ch = i;
        end
        ch_valid = mask;
        if (acc) begin
            for (int i = 0; i < NC; i++) begin
                if (mask[i]) begin
                    b.data = ch_data[i];
                    b.ch   = 2'(i);
                    b.last = fin && (i == top_ch);
                    exp_q.push_back(b);
                end
            end
        end
        cyc(1);
        ch_valid = '0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        m_if.m_ready = 1'b1;
        cyc(2);
        vec_cnt++;
        if ({m_if.m_valid, m_if.m_last, busy, done, overflow} !== 5'b0) begin
            err_cnt++;
            $display("FAIL reset_status: got valid/last/busy/done/ovf=%b required 00000",
                     {m_if.m_valid, m_if.m_last, busy, done, overflow});
        end
        vec_cnt++;
        if ({m_if.m_data, m_if.m_ch} !== '0) begin
            err_cnt++;
            $display("FAIL reset_data: got data=%h ch=%0d required 0/0", m_if.m_data, m_if.m_ch);
        end
        // A start in the very first cycle after release is still inside the synchronizer window.
        rstn = 1'b1;
        do_start(16'd5);
        vec_cnt++;
        if (busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_sync_start: got busy=%b required 0", busy);
        end
        cyc(3);
    endtask

    task automatic test_zero_reads();
        done_cnt = 0;
        do_start(16'd0);
        vec_cnt++;
        if ({done, busy, m_if.m_valid} !== 3'b100) begin
            err_cnt++;
            $display("FAIL zero_reads: got done/busy/valid=%b required 100", {done, busy, m_if.m_valid});
        end
        cyc(3);
        vec_cnt++;
        if (done_cnt !== 1 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL zero_reads_once: got done_cnt=%0d busy=%b required 1/0", done_cnt, busy);
        end
    endtask

    task automatic test_frames();
        m_if.m_ready = 1'b1;
        done_cnt = 0;
        beat_cnt = 0;
        do_start(16'd3);
        vec_cnt++;
        if (busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL frames_busy: got %b required 1", busy);
        end
        cyc(2);
        pulse(4'hF, 1'b1, 1'b0);
        cyc(5);
        // A start while capturing must not disturb the count.
        num_reads = 16'd7;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        pulse(4'hF, 1'b1, 1'b0);
        cyc(5);
        pulse(4'hF, 1'b1, 1'b1);
        cyc(12);
        vec_cnt++;
        if (beat_cnt !== 12 || exp_q.size() != 0) begin
            err_cnt++;
            $display("FAIL frames_count: got beats=%0d pending=%0d required 12/0", beat_cnt, exp_q.size());
        end
        vec_cnt++;
        if (done_cnt !== 1 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL frames_done: got done_cnt=%0d busy=%b required 1/0", done_cnt, busy);
        end
    endtask

    task automatic test_arm_discard();
        done_cnt = 0;
        beat_cnt = 0;
        do_start(16'd1);
        pulse(4'hE, 1'b0, 1'b0);
        cyc(1);
        pulse(4'h6, 1'b0, 1'b0);
        cyc(4);
        vec_cnt++;
        if (beat_cnt !== 0 || m_if.m_valid !== 1'b0 || busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL arm_discard: got beats=%0d valid=%b busy=%b required 0/0/1",
                     beat_cnt, m_if.m_valid, busy);
        end
        pulse(4'hF, 1'b1, 1'b1);
        vec_cnt++;
        if (m_if.m_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL latency_1: got valid=%b required 0", m_if.m_valid);
        end
        cyc(1);
        vec_cnt++;
        if (m_if.m_valid !== 1'b1) begin
            err_cnt++;
            $display("FAIL latency_2: got valid=%b required 1", m_if.m_valid);
        end
        cyc(8);
        vec_cnt++;
        if (beat_cnt !== 4 || exp_q.size() != 0 || done_cnt !== 1) begin
            err_cnt++;
            $display("FAIL arm_frame: got beats=%0d pending=%0d done_cnt=%0d required 4/0/1",
                     beat_cnt, exp_q.size(), done_cnt);
        end
    endtask

    task automatic test_overflow();
        beat_t b;
        m_if.m_ready = 1'b0;
        done_cnt = 0;
        beat_cnt = 0;
        do_start(16'd2);
        cyc(1);
        pulse(4'hF, 1'b1, 1'b0);
        cyc(3);
        // Channel 0's frame-1 word already moved into the output register, so its frame-2
        // word finds an empty buffer; channels 1..3 are still full and drop theirs.
        pulse(4'hF, 1'b0, 1'b0);
        b.data = ch_data[0];
        b.ch   = 2'd0;
        b.last = 1'b1;
        exp_q.push_back(b);
        vec_cnt++;
        if ({overflow, busy, m_if.m_valid} !== 3'b111 || m_if.m_ch !== 2'd0) begin
            err_cnt++;
            $display("FAIL overflow_set: got ovf/busy/valid=%b ch=%0d required 111 ch=0",
                     {overflow, busy, m_if.m_valid}, m_if.m_ch);
        end
        cyc(3);
        m_if.m_ready = 1'b1;
        cyc(10);
        vec_cnt++;
        if (beat_cnt !== 5 || exp_q.size() != 0 || done_cnt !== 1) begin
            err_cnt++;
            $display("FAIL overflow_drain: got beats=%0d pending=%0d done_cnt=%0d required 5/0/1",
                     beat_cnt, exp_q.size(), done_cnt);
        end
        vec_cnt++;
        if (overflow !== 1'b1) begin
            err_cnt++;
            $display("FAIL overflow_sticky: got %b required 1", overflow);
        end
    endtask

    task automatic test_abort();
        m_if.m_ready = 1'b0;
        done_cnt = 0;
        do_start(16'd5);
        vec_cnt++;
        if (overflow !== 1'b0) begin
            err_cnt++;
            $display("FAIL start_clears_ovf: got %b required 0", overflow);
        end
        pulse(4'hF, 1'b1, 1'b0);
        cyc(2);
        vec_cnt++;
        if (m_if.m_valid !== 1'b1 || busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL abort_pre: got valid=%b busy=%b required 1/1", m_if.m_valid, busy);
        end
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        exp_q.delete();
        vec_cnt++;
        if ({m_if.m_valid, m_if.m_last, busy} !== 3'b000) begin
            err_cnt++;
            $display("FAIL abort_clear: got valid/last/busy=%b required 000", {m_if.m_valid, m_if.m_last, busy});
        end
        m_if.m_ready = 1'b1;
        beat_cnt = 0;
        cyc(4);
        vec_cnt++;
        if (done_cnt !== 0 || beat_cnt !== 0) begin
            err_cnt++;
            $display("FAIL abort_quiet: got done_cnt=%0d beats=%0d required 0/0", done_cnt, beat_cnt);
        end
        do_start(16'd1);
        vec_cnt++;
        if (busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL abort_restart: got busy=%b required 1", busy);
        end
        pulse(4'hF, 1'b1, 1'b1);
        cyc(8);
        vec_cnt++;
        if (beat_cnt !== 4 || exp_q.size() != 0 || done_cnt !== 1) begin
            err_cnt++;
            $display("FAIL abort_next: got beats=%0d pending=%0d done_cnt=%0d required 4/0/1",
                     beat_cnt, exp_q.size(), done_cnt);
        end
    endtask

    task automatic test_reset_drain();
        m_if.m_ready = 1'b0;
        do_start(16'd2);
        pulse(4'hF, 1'b0, 1'b0);
        d0 = ch_data[0];
        cyc(2);
        pulse(4'hF, 1'b0, 1'b0);
        vec_cnt++;
        if ({overflow, busy, m_if.m_valid} !== 3'b111 || m_if.m_data !== d0) begin
            err_cnt++;
            $display("FAIL drain_pre: got ovf/busy/valid=%b data=%h required 111 data=%h",
                     {overflow, busy, m_if.m_valid}, m_if.m_data, d0);
        end
        #2;
        rstn = 1'b0;
        #1;
        vec_cnt++;
        if ({m_if.m_valid, m_if.m_last, busy, done, overflow} !== 5'b0) begin
            err_cnt++;
            $display("FAIL async_reset_status: got valid/last/busy/done/ovf=%b required 00000",
                     {m_if.m_valid, m_if.m_last, busy, done, overflow});
        end
        vec_cnt++;
        if ({m_if.m_data, m_if.m_ch} !== '0) begin
            err_cnt++;
            $display("FAIL async_reset_data: got data=%h ch=%0d required 0/0", m_if.m_data, m_if.m_ch);
        end
        cyc(1);
        rstn = 1'b1;
        cyc(3);
        vec_cnt++;
        if (busy !== 1'b0 || m_if.m_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL post_reset: got busy=%b valid=%b required 0/0", busy, m_if.m_valid);
        end
    endtask

    initial begin
        m_if.m_ready = 1'b1;
        test_reset();
        test_zero_reads();
        test_frames();
        test_arm_discard();
        test_overflow();
        test_abort();
        test_reset_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
